// File: rtl/instr_loader.sv
// Byte-stream program loader and run controller ahead of the pipeline's IF memory.
// Optional build macro STEP_MODE_EN adds a single-cycle 'S' step command.
module instr_loader #(
  parameter int NB_DATA        = 32,
  parameter int NB_BYTE        = 8,
  parameter int MEM_WORDS      = 64,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_pipe_halted,
  output logic               o_we_IF,
  output logic [NB_DATA-1:0] o_instruction_data,
  output logic [NB_DATA-1:0] o_inst_addr,
  output logic               o_halt,
  output logic               o_pipe_rst_n,
  output logic               o_busy,
  output logic               o_overflow
);

  localparam int LP_BYTES = NB_DATA / NB_BYTE;
  localparam int LP_CNT_W = $clog2(LP_BYTES);
  localparam int LP_TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LP_CNT_W-1:0] LP_LAST_BYTE = LP_CNT_W'(LP_BYTES - 1);
  localparam logic [LP_TO_W-1:0]  LP_TO_LAST   = LP_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NB_DATA-1:0]  LP_MAX_ADDR  = NB_DATA'(4 * (MEM_WORDS - 1));
  localparam logic [NB_DATA-1:0]  LP_ADDR_STEP = NB_DATA'(4);

  localparam logic [NB_BYTE-1:0] LP_CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] LP_CMD_RUN  = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] LP_CMD_HALT = NB_BYTE'(8'h48);
`ifdef STEP_MODE_EN
  localparam logic [NB_BYTE-1:0] LP_CMD_STEP = NB_BYTE'(8'h53);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_PRERUN,
    S_RUN,
    S_STEP
  } state_t;

  state_t                r_state;
  logic [NB_DATA-1:0]    r_word;
  logic [NB_DATA-1:0]    r_addr;
  logic [LP_CNT_W-1:0]   r_byte_cnt;
  logic [LP_TO_W-1:0]    r_to_cnt;

  logic [NB_DATA-1:0]    w_word_next;
  logic                  w_word_is_halt;

  assign w_word_next    = {r_word[NB_DATA-NB_BYTE-1:0], i_rx_data};
  assign w_word_is_halt = (r_word[NB_DATA-1 -: 6] == 6'b111111);

  // NOTE: every register here is state, so all updates are non-blocking; a
  // blocking assignment would let later branches see the new value mid-cycle.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state            <= S_IDLE;
      r_word             <= '0;
      r_addr             <= '0;
      r_byte_cnt         <= '0;
      r_to_cnt           <= '0;
      o_we_IF            <= 1'b0;
      o_instruction_data <= '0;
      o_inst_addr        <= '0;
      o_halt             <= 1'b1;
      o_pipe_rst_n       <= 1'b0;
      o_busy             <= 1'b0;
      o_overflow         <= 1'b0;
    end else begin
      o_we_IF <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_halt       <= 1'b1;
          o_pipe_rst_n <= 1'b1;
          o_busy       <= 1'b0;
          if (i_rx_valid) begin
            if (i_rx_data == LP_CMD_LOAD) begin
              r_state    <= S_LOAD;
              r_addr     <= '0;
              r_byte_cnt <= '0;
              r_to_cnt   <= '0;
              o_overflow <= 1'b0;
              o_busy     <= 1'b1;
            end else if (i_rx_data == LP_CMD_RUN) begin
              r_state      <= S_PRERUN;
              o_pipe_rst_n <= 1'b0;
              o_busy       <= 1'b1;
            end
`ifdef STEP_MODE_EN
            else if (i_rx_data == LP_CMD_STEP) begin
              r_state <= S_STEP;
              o_halt  <= 1'b0;
              o_busy  <= 1'b1;
            end
`endif
          end
        end

        S_LOAD: begin
          if (i_rx_valid) begin
            r_word   <= w_word_next;
            r_to_cnt <= '0;
            if (r_byte_cnt == LP_LAST_BYTE) begin
              // Write outputs are launched here so o_we_IF is high during WRITE.
              r_byte_cnt <= '0;
              r_state    <= S_WRITE;
              if (r_addr <= LP_MAX_ADDR) begin
                o_we_IF            <= 1'b1;
                o_instruction_data <= w_word_next;
                o_inst_addr        <= r_addr;
                r_addr             <= r_addr + LP_ADDR_STEP;
              end else begin
                o_overflow <= 1'b1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end else if (r_byte_cnt != '0) begin
            if (r_to_cnt == LP_TO_LAST) begin
              r_state    <= S_IDLE;
              r_byte_cnt <= '0;
              r_to_cnt   <= '0;
              o_busy     <= 1'b0;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end

        S_WRITE: begin
          r_to_cnt <= '0;
          if (w_word_is_halt) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            o_busy     <= 1'b0;
          end else begin
            r_state <= S_LOAD;
            if (i_rx_valid) begin
              r_word     <= w_word_next;
              r_byte_cnt <= LP_CNT_W'(1);
            end
          end
        end

        S_PRERUN: begin
          r_state      <= S_RUN;
          o_halt       <= 1'b0;
          o_pipe_rst_n <= 1'b1;
        end

        S_RUN: begin
          if (i_pipe_halted || (i_rx_valid && (i_rx_data == LP_CMD_HALT))) begin
            r_state <= S_IDLE;
            o_halt  <= 1'b1;
            o_busy  <= 1'b0;
          end
        end

`ifdef STEP_MODE_EN
        S_STEP: begin
          r_state <= S_IDLE;
          o_halt  <= 1'b1;
          o_busy  <= 1'b0;
        end
`endif

        default: begin
          r_state <= S_IDLE;
          o_halt  <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed sequences, a run-control vector
// table, and randomized byte traffic against a transaction-level loader model.
module tb_instr_loader;

  localparam int MEM_WORDS = 4;
  localparam int TO_CYC    = 40;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_pipe_halted;
  logic        o_we_IF;
  logic [31:0] o_instruction_data;
  logic [31:0] o_inst_addr;
  logic        o_halt;
  logic        o_pipe_rst_n;
  logic        o_busy;
  logic        o_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  instr_loader #(
    .NB_DATA       (32),
    .NB_BYTE       (8),
    .MEM_WORDS     (MEM_WORDS),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk               (clk),
    .i_rst             (i_rst),
    .i_rx_data         (i_rx_data),
    .i_rx_valid        (i_rx_valid),
    .i_pipe_halted     (i_pipe_halted),
    .o_we_IF           (o_we_IF),
    .o_instruction_data(o_instruction_data),
    .o_inst_addr       (o_inst_addr),
    .o_halt            (o_halt),
    .o_pipe_rst_n      (o_pipe_rst_n),
    .o_busy            (o_busy),
    .o_overflow        (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       halted;
    logic       exp_halt;
    logic       exp_busy;
    logic       exp_prst;
  } vec_t;
  vec_t tbl[15];

  typedef enum {M_IDLE, M_LOAD, M_RUN} mmode_t;
  mmode_t     m_mode;
  logic [7:0] m_bytes[$];
  int         m_addr;
  logic       m_ovf;
  logic       m_dead;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send(w[k*8 +: 8]);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{a, d});
  endtask

  // Write scoreboard: every IF write must match the oldest expected write.
  always @(negedge clk) begin
    if (!i_rst && o_we_IF) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                 o_inst_addr, o_instruction_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", o_inst_addr, mon_e.addr);
        check("wr_data", o_instruction_data, mon_e.data);
      end
    end
  end

  // Loader model, one received event at a time. gap = cycles since the previous event.
  task automatic model_event(input logic is_byte, input logic [7:0] b, input int gap);
    logic [31:0] w;
    logic        dead_hit;
    dead_hit = m_dead && (gap == 1);
    m_dead   = 1'b0;
    if (dead_hit) return;
    if (!is_byte) begin
      if (m_mode == M_RUN) m_mode = M_IDLE;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (b == 8'h4C) begin
          m_mode = M_LOAD;
          m_bytes.delete();
          m_addr = 0;
          m_ovf  = 1'b0;
        end else if (b == 8'h52) begin
          m_mode = M_RUN;
          m_dead = 1'b1;
        end
      end
      M_RUN: if (b == 8'h48) m_mode = M_IDLE;
      default: begin
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
          w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_bytes.delete();
          if (m_addr <= 4 * (MEM_WORDS - 1)) begin
            expect_wr(m_addr, w);
            m_addr = m_addr + 4;
          end else begin
            m_ovf = 1'b1;
          end
          if (w[31:26] == 6'b111111) begin
            m_mode = M_IDLE;
            m_dead = 1'b1;
          end
        end
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst         = 1'b1;
    i_rx_data     = 8'h00;
    i_rx_valid    = 1'b0;
    i_pipe_halted = 1'b0;

    // Reset values, and pipeline reset release on the first clock afterwards.
    idle(2);
    check("rst_we", o_we_IF, 0);
    check("rst_data", o_instruction_data, 0);
    check("rst_addr", o_inst_addr, 0);
    check("rst_halt", o_halt, 1);
    check("rst_prst", o_pipe_rst_n, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovf", o_overflow, 0);
    i_rst = 1'b0;
    #1;
    check("prst_before_clk", o_pipe_rst_n, 0);
    tick();
    check("prst_after_clk", o_pipe_rst_n, 1);

    // Two-word load; second word is HALT and starts in the WRITE cycle.
    send(8'h4C);
    check("load_busy", o_busy, 1);
    expect_wr(32'h0, 32'h2001000F);
    expect_wr(32'h4, 32'hFC000000);
    send_word(32'h2001000F);
    check("we_latency_w0", o_we_IF, 1);
    send_word(32'hFC000000);
    check("we_latency_w1", o_we_IF, 1);
    idle(3);
    check("t1_idle_busy", o_busy, 0);
    check("t1_halt", o_halt, 1);
    check("t1_drained", exp_q.size(), 0);

    // Partial word abandoned after the idle timeout.
    send(8'h4C);
    send(8'h11); send(8'h22); send(8'h33);
    idle(TO_CYC - 3);
    check("to_still_busy", o_busy, 1);
    idle(10);
    check("to_idle", o_busy, 0);
    check("to_no_write", exp_q.size(), 0);
    send(8'h4C);
    expect_wr(32'h0, 32'h0A0B0C0D);
    expect_wr(32'h4, 32'hFC000001);
    send_word(32'h0A0B0C0D);
    send_word(32'hFC000001);
    idle(3);
    check("to_drained", exp_q.size(), 0);

    // Memory-full overflow: five words into a four-word memory.
    send(8'h4C);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_wr(32'(4 * i), {8'h10 + 8'(i), 16'h0, 8'(i)});
      send_word({8'h10 + 8'(i), 16'h0, 8'(i)});
      if (i == 3) check("ovf_before", o_overflow, 0);
    end
    check("ovf_after", o_overflow, 1);
    send_word(32'hFFFFFFFF);
    idle(3);
    check("ovf_idle", o_busy, 0);
    check("ovf_sticky", o_overflow, 1);
    check("ovf_drained", exp_q.size(), 0);
    send(8'h4C);
    check("ovf_cleared", o_overflow, 0);
    expect_wr(32'h0, 32'hFC000002);
    send_word(32'hFC000002);
    idle(3);

    // Run-control vectors, applied one cycle each from IDLE.
    tbl[0]  = '{1'b1, 8'h52, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'h52, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 8'h48, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'h52, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 8'h48, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef STEP_MODE_EN
    tbl[13] = '{1'b1, 8'h53, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    tbl[13] = '{1'b1, 8'h53, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 15; i++) begin
      i_rx_valid    = tbl[i].valid;
      i_rx_data     = tbl[i].data;
      i_pipe_halted = tbl[i].halted;
      tick();
      i_rx_valid    = 1'b0;
      i_pipe_halted = 1'b0;
      check($sformatf("vec%0d_halt", i), o_halt, tbl[i].exp_halt);
      check($sformatf("vec%0d_busy", i), o_busy, tbl[i].exp_busy);
      check($sformatf("vec%0d_prst", i), o_pipe_rst_n, tbl[i].exp_prst);
    end

    // Asynchronous reset in the middle of a word.
    send(8'h4C);
    send(8'hAA); send(8'hBB);
    #2 i_rst = 1'b1;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_halt", o_halt, 1);
    check("arst_prst", o_pipe_rst_n, 0);
    check("arst_data", o_instruction_data, 0);
    check("arst_addr", o_inst_addr, 0);
    tick();
    i_rst = 1'b0;
    tick();
    send(8'h4C);
    expect_wr(32'h0, 32'hFC000007);
    send_word(32'hFC000007);
    idle(3);
    check("arst_reload_drained", exp_q.size(), 0);

    // Randomized traffic against the model.
    m_mode = M_IDLE;
    m_addr = 0;
    m_ovf  = 1'b0;
    m_dead = 1'b0;
    m_bytes.delete();
    for (int n = 0; n < 400; n++) begin
      int         gap;
      int         sel;
      logic [7:0] b;
      logic       is_byte;
      gap = $urandom_range(1, 4);
      repeat (gap - 1) tick();
      if (gap >= 2) begin
        check("rnd_halt", o_halt, (m_mode != M_RUN));
        check("rnd_busy", o_busy, (m_mode != M_IDLE));
        check("rnd_ovf", o_overflow, m_ovf);
      end
      sel     = $urandom_range(0, 11);
      is_byte = (sel != 11);
      case (sel)
        0:       b = 8'h4C;
        1:       b = 8'h52;
        2:       b = 8'h48;
        3:       b = 8'hFC | 8'($urandom_range(0, 3));
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (b == 8'h53) b = 8'h54;
      model_event(is_byte, b, gap);
      i_rx_data     = b;
      i_rx_valid    = is_byte;
      i_pipe_halted = !is_byte;
      tick();
      i_rx_valid    = 1'b0;
      i_pipe_halted = 1'b0;
    end
    idle(4);
    check("rnd_end_halt", o_halt, (m_mode != M_RUN));
    check("rnd_end_busy", o_busy, (m_mode != M_IDLE));
    check("rnd_end_ovf", o_overflow, m_ovf);
    check("rnd_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
